// File: rtl/stage_id_hz.sv
// Decode stage: IF->ID pipeline register, priority operand forwarding, load-use/back-pressure stalls.
// Optional performance counters are compiled in when STAGE_ID_PERF_EN is defined.
module stage_id_hz #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NFWD = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if_valid,
   input  logic [XLEN-1:0]      if_pc,
   input  logic [XLEN-1:0]      if_nextpc,
   input  logic [31:0]          if_instr,
   output logic                 id_stall,
   output logic [31:0]          instr,
   input  logic [4:0]           dec_rs1,
   input  logic [4:0]           dec_rs2,
   input  logic                 dec_use_rs1,
   input  logic                 dec_use_rs2,
   input  logic                 dec_op2_imm,
   input  logic [XLEN-1:0]      dec_imm,
   input  logic                 dec_branch_op1,
   input  logic [XLEN-1:0]      dec_branch_off,
   output logic [4:0]           rf_rs1_addr,
   output logic [4:0]           rf_rs2_addr,
   input  logic [XLEN-1:0]      rf_rs1_data,
   input  logic [XLEN-1:0]      rf_rs2_data,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD-1:0]      fwd_ready,
   input  logic [NFWD*5-1:0]    fwd_rd,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic                 flush,
   input  logic                 ex_ready,
   output logic                 id_valid,
   output logic [XLEN-1:0]      id_pc,
   output logic [XLEN-1:0]      id_nextpc,
   output logic [XLEN-1:0]      op1,
   output logic [XLEN-1:0]      op2,
   output logic [XLEN-1:0]      branch_dest,
   output logic [31:0]          perf_stall_cnt,
   output logic [31:0]          perf_flush_cnt
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d, nextpc_q, nextpc_d;
   logic [31:0]     instr_q, instr_d;

   logic            hit1, rdy1, hit2, rdy2, hazard;
   logic [XLEN-1:0] fdat1, fdat2;

   assign rf_rs1_addr = dec_rs1;
   assign rf_rs2_addr = dec_rs2;

   // Scan oldest to youngest so the youngest (lowest index) match overwrites the rest.
   always_comb begin
      hit1  = 1'b0;
      rdy1  = 1'b0;
      fdat1 = '0;
      hit2  = 1'b0;
      rdy2  = 1'b0;
      fdat2 = '0;
      for (int k = int'(NFWD) - 1; k >= 0; k--) begin
         if (fwd_valid[k] && fwd_rd[k*5 +: 5] == dec_rs1 && dec_rs1 != 5'd0) begin
            hit1  = 1'b1;
            rdy1  = fwd_ready[k];
            fdat1 = fwd_data[k*XLEN +: XLEN];
         end
         if (fwd_valid[k] && fwd_rd[k*5 +: 5] == dec_rs2 && dec_rs2 != 5'd0) begin
            hit2  = 1'b1;
            rdy2  = fwd_ready[k];
            fdat2 = fwd_data[k*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      op1 = hit1 ? fdat1 : rf_rs1_data;
      if (dec_rs1 == 5'd0) op1 = '0;
      op2 = hit2 ? fdat2 : rf_rs2_data;
      if (dec_rs2 == 5'd0) op2 = '0;
      if (dec_op2_imm)     op2 = dec_imm;
   end

   assign hazard = valid_q &&
                   ((dec_use_rs1 && hit1 && !rdy1) ||
                    (dec_use_rs2 && !dec_op2_imm && hit2 && !rdy2));

   assign id_valid    = valid_q && !hazard && !flush;
   assign id_stall    = !flush && valid_q && (hazard || !ex_ready);
   assign branch_dest = dec_branch_op1 ? op1 : pc_q + dec_branch_off;
   assign instr       = instr_q;
   assign id_pc       = pc_q;
   assign id_nextpc   = nextpc_q;

   // Flush kills the slot but still tracks IF; a stall freezes everything.
   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      nextpc_d = nextpc_q;
      instr_d  = instr_q;
      if (flush || !id_stall) begin
         valid_d  = flush ? 1'b0 : if_valid;
         pc_d     = if_pc;
         nextpc_d = if_nextpc;
         instr_d  = if_instr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         nextpc_q <= '0;
         instr_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         nextpc_q <= nextpc_d;
         instr_q  <= instr_d;
      end
   end

`ifdef STAGE_ID_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hazard && !flush && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush && valid_q && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/stage_id_hz.md
# stage_id_hz

Parametrised successor to the decode stage. It holds the IF→ID pipeline register, drives the external decoder and register-file read ports, and resolves operands through an N-deep priority forwarding network. Unlike the previous stage, it detects load-use hazards and back-pressure, stalling IF and inserting bubbles into EX. It sits between stage IF and stage EX.

## Interface
Parameters:
- XLEN, 32, datapath width
- NFWD, 3, number of forwarding sources; index 0 is youngest and has highest priority (EX, MEM, WB)

Ports (async, active-low reset, one clock):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF presents an instruction
- if_pc, if_nextpc  in  XLEN  IF instruction addresses
- if_instr  in  32  IF instruction word
- id_stall  out  1  IF must hold its outputs this cycle
- instr  out  32  registered instruction, to decoder
- dec_rs1, dec_rs2  in  5  decoded source indices
- dec_use_rs1, dec_use_rs2  in  1  source actually read
- dec_op2_imm  in  1  op2 comes from immediate
- dec_imm  in  XLEN  decoded immediate
- dec_branch_op1  in  1  branch target = op1 (register jump)
- dec_branch_off  in  XLEN  PC-relative branch offset
- rf_rs1_addr, rf_rs2_addr  out  5  register-file read addresses (= dec_rs1/2)
- rf_rs1_data, rf_rs2_data  in  XLEN  register-file read data
- fwd_valid  in  NFWD  source writes rd
- fwd_ready  in  NFWD  source result available this cycle (0 for load in EX)
- fwd_rd  in  NFWD×5  destination index per source
- fwd_data  in  NFWD×XLEN  result per source
- flush  in  1  taken branch in EX; kill ID
- ex_ready  in  1  EX accepts ID output this cycle
- id_valid  out  1  ID output is a real instruction (inverse of the bubble)
- id_pc, id_nextpc  out  XLEN  registered PCs
- op1, op2  out  XLEN  resolved operands
- branch_dest  out  XLEN  branch target
- perf_stall_cnt, perf_flush_cnt  out  32  performance counters (see Configuration)

## Operation
- Register set: valid_q, pc_q, nextpc_q, instr_q. Reset values: all 0; id_valid is 0.
- Forward match for source k: fwd_valid[k] && fwd_rd[k]==rsX && rsX!=0. The lowest matching k wins.
- Operand selection:
  - Winning match with fwd_ready=1: use fwd_data[k].
  - No match: use rf data.
  - rsX==0: value is 0.
  - op2 = dec_imm when dec_op2_imm=1.
- hazard = valid_q && any used source (op2 only when !dec_op2_imm) whose winning match has fwd_ready=0. A lower-priority ready match never overrides a higher-priority unready one.
- branch_dest = dec_branch_op1 ? op1 : pc_q + dec_branch_off, modulo 2^XLEN.
- id_valid = valid_q && !hazard && !flush.
- id_stall = !flush && valid_q && (hazard || !ex_ready).
- Register update priority:
  - flush: valid_q←0; other fields ← IF values.
  - id_stall: hold all registers.
  - otherwise: capture IF; valid_q←if_valid.
- No state machine beyond the valid/hold register. Hazard and stall are recomputed every cycle.

## Timing
- IF→ID latency: 1 cycle. Operands, id_valid, id_stall and branch_dest are combinational from the registers and the current-cycle forwarding inputs.
- Load-use: a consumer behind a load stalls exactly until the load's fwd_ready rises or the load leaves every forwarding slot. Bubbles are emitted every stall cycle.
- ex_ready=0 with no hazard: id_valid stays 1 and outputs are stable until acceptance.
- flush together with hazard or !ex_ready: flush wins, id_valid=0 that cycle, no stall.
- rst_n assertion mid-stall clears valid_q immediately (asynchronous). The first capture happens on the first rising edge after deassertion.

## Configuration
- STAGE_ID_PERF_EN defined:
  - perf_stall_cnt increments on each cycle with hazard && !flush.
  - perf_flush_cnt increments on each cycle with flush && valid_q.
  - Both counters are 32-bit, saturate at 0xFFFF_FFFF and reset to 0.
- Not defined: counter registers are omitted and both ports read constant 0.

## Test plan
- Back-to-back ALU dependency: EX writes x5=0x1234 (ready), ID reads x5 as rs1 → op1=0x1234, id_valid=1, id_stall=0.
- Load-use: EX slot has rd=x7, ready=0, and ID uses x7. Cycle 1: id_valid=0, id_stall=1. Next cycle MEM slot rd=x7 ready, data 0xAA → op1=0xAA, id_valid=1.
- Priority and x0:
  - EX rd=x3=1 and MEM rd=x3=2 → op1=1.
  - Writers to x0 with data 0xFFFF_FFFF and ID reads x0 → op1=0.
- Immediate bypass: dec_op2_imm=1, imm=0x10, unready EX rd=rs2 → no hazard, op2=0x10.
- Flush during stall: hazard active and flush=1 → id_valid=0, id_stall=0. Next cycle valid_q=0. With the macro defined, perf_flush_cnt=1.
- Back-pressure and reset: ex_ready=0 for 3 cycles → outputs held and id_stall=1. Drop rst_n mid-hold → id_valid=0 immediately and counters read 0.
